// File: rtl/vunpack_if.sv
// Bundle of the vunpack handshake, data and status signals.
// The slave modport is the unpacker; the master modport is the producer/consumer side.
interface vunpack_if #(
    parameter int VLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [VLEN-1:0] in_data;
    logic [2:0]      in_sew;
    logic [3:0]      in_vl;
    logic            in_signed;
    logic [7:0]      in_mask;
    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] out_data;
    logic [2:0]      out_idx;
    logic            out_last;
    logic            err;

    modport slave (
        input  in_valid, in_data, in_sew, in_vl, in_signed, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, err
    );

    modport master (
        output in_valid, in_data, in_sew, in_vl, in_signed, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, err
    );
endinterface

// File: rtl/vunpack.sv
// Unpacks a 64-bit packed vector into one sign/zero-extended element per cycle.
// Optional element masking is enabled by defining VUNPACK_MASK_EN.
module vunpack #(
    parameter int VLEN = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    vunpack_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_rdy;
    logic [VLEN-1:0] r_data;
    logic [1:0]      r_sew;
    logic            r_signed;
    logic [3:0]      r_vl;
    logic [2:0]      r_idx;
    logic            r_err;

    logic [2:0]      w_idx_next;
    logic            w_err_next;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_sew_bad;
    logic [3:0]      w_in_cap;
    logic [3:0]      w_eff_vl;
    logic [7:0]      w_mask_in;
    logic [7:0]      w_mask_cur;
    logic [7:0]      w_in_act;
    logic [7:0]      w_act;
    logic [7:0]      w_upto;
    logic [7:0]      w_above;
    logic            w_has_in;
    logic            w_has_next;
    logic [2:0]      w_first_in;
    logic [2:0]      w_next_idx;
    logic [6:0]      w_shamt;
    logic [VLEN-1:0] w_shifted;
    logic [VLEN-1:0] w_elem;

`ifdef VUNPACK_MASK_EN
    logic [7:0]      r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= bus.in_mask;
        end
    end

    assign w_mask_in  = bus.in_mask;
    assign w_mask_cur = r_mask;
`else
    assign w_mask_in  = '1;
    assign w_mask_cur = '1;
`endif

    function automatic logic [2:0] f_lowest(input logic [7:0] v);
        f_lowest = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) f_lowest = 3'(k);
        end
    endfunction

    // Effective length is the request clipped to how many elements fit at this SEW.
    assign w_sew_bad  = bus.in_sew[2];
    assign w_in_cap   = 4'd8 >> bus.in_sew[1:0];
    assign w_eff_vl   = (bus.in_vl < w_in_cap) ? bus.in_vl : w_in_cap;
    assign w_in_ready = (r_state == ST_IDLE) && r_rdy;
    assign w_accept   = bus.in_valid && w_in_ready;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_act
            assign w_in_act[gi] = (4'(gi) < w_eff_vl) && w_mask_in[gi];
            assign w_act[gi]    = (4'(gi) < r_vl) && w_mask_cur[gi];
        end
    endgenerate

    // Thermometer of indices 0..r_idx; anything active above it is still pending.
    assign w_upto     = (8'd2 << r_idx) - 8'd1;
    assign w_above    = w_act & ~w_upto;
    assign w_has_in   = |w_in_act;
    assign w_has_next = |w_above;
    assign w_first_in = f_lowest(w_in_act);
    assign w_next_idx = f_lowest(w_above);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_sew_bad) begin
                        w_err_next = 1'b1;
                    end else if (w_has_in) begin
                        w_state_next = ST_STREAM;
                        w_idx_next   = w_first_in;
                    end
                end
            end
            ST_STREAM: begin
                if (bus.out_ready) begin
                    if (w_has_next) begin
                        w_idx_next = w_next_idx;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_err   <= w_err_next;
            r_rdy   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_sew    <= '0;
            r_signed <= 1'b0;
            r_vl     <= '0;
        end else if (w_accept) begin
            r_data   <= bus.in_data;
            r_sew    <= bus.in_sew[1:0];
            r_signed <= bus.in_signed;
            r_vl     <= w_eff_vl;
        end
    end

    // Bit offset of the current element is idx * 8 * 2^sew.
    assign w_shamt   = {1'b0, r_idx, 3'b000} << r_sew;
    assign w_shifted = r_data >> w_shamt;

    always_comb begin
        w_elem = w_shifted;
        case (r_sew)
            2'd0: w_elem = {{(VLEN-8){r_signed & w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_elem = {{(VLEN-16){r_signed & w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_elem = {{(VLEN-32){r_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: w_elem = w_shifted;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_STREAM);
    assign bus.out_data  = w_elem;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = (r_state == ST_STREAM) && !w_has_next;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_vunpack.sv
// Directed and randomized bench for vunpack against a queue-based element model.
module tb_vunpack;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

`ifdef VUNPACK_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    vunpack_if #(.VLEN(64)) u_if ();

    vunpack #(.VLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct {
        int          idx;
        logic [63:0] data;
    } beat_t;

    beat_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ext_elem(input logic [63:0] d, input int sew, input int i, input bit sgn);
        int          w;
        logic [63:0] e;
        logic [63:0] lowmask;
        w = 8 << sew;
        e = d >> (i * w);
        if (w < 64) begin
            lowmask = (64'd1 << w) - 64'd1;
            e = e & lowmask;
            if (sgn && e[w-1]) e = e | ~lowmask;
        end
        return e;
    endfunction

    task automatic build_model(input logic [63:0] d, input int sew, input int vl, input bit sgn,
                               input logic [7:0] mask);
        int    fit;
        int    eff;
        beat_t b;
        exp_q.delete();
        if (sew > 3) return;
        fit = 64 / (8 << sew);
        eff = (vl < fit) ? vl : fit;
        for (int i = 0; i < eff; i++) begin
            if (MASK_EN && !mask[i]) continue;
            b.idx  = i;
            b.data = ext_elem(d, sew, i, sgn);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_ready(input string name);
        int guard;
        guard = 0;
        while (u_if.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({name, ".in_ready"}, 64'(u_if.in_ready), 64'd1);
    endtask

    task automatic offer(input logic [63:0] d, input int sew, input int vl, input bit sgn,
                         input logic [7:0] mask);
        u_if.in_valid  = 1'b1;
        u_if.in_data   = d;
        u_if.in_sew    = 3'(sew);
        u_if.in_vl     = 4'(vl);
        u_if.in_signed = sgn;
        u_if.in_mask   = mask;
        @(negedge clk);
        // Scramble the inputs so a design that failed to capture would show it.
        u_if.in_valid  = 1'b0;
        u_if.in_data   = {$urandom, $urandom};
        u_if.in_sew    = 3'($urandom_range(0, 7));
        u_if.in_vl     = 4'($urandom_range(0, 8));
        u_if.in_signed = 1'($urandom_range(0, 1));
        u_if.in_mask   = 8'($urandom);
    endtask

    // mode 0: out_ready always 1; 1: toggles starting at 0; 2: random.
    task automatic run_vec(input string name, input logic [63:0] d, input int sew, input int vl,
                           input bit sgn, input logic [7:0] mask, input int mode);
        int n;
        int k;
        int guard;
        bit rdy;
        bit tog;
        build_model(d, sew, vl, sgn, mask);
        n = exp_q.size();
        u_if.out_ready = 1'b0;
        wait_ready(name);
        offer(d, sew, vl, sgn, mask);
        check({name, ".err"}, 64'(u_if.err), 64'(sew > 3));
        if (n == 0) begin
            check({name, ".no_valid"}, 64'(u_if.out_valid), 64'd0);
            check({name, ".idle"}, 64'(u_if.in_ready), 64'd1);
            @(negedge clk);
            check({name, ".err_off"}, 64'(u_if.err), 64'd0);
            check({name, ".no_valid2"}, 64'(u_if.out_valid), 64'd0);
        end else begin
            k = 0;
            guard = 0;
            tog = 1'b0;
            while (k < n && guard < 200) begin
                check($sformatf("%s.valid[%0d]", name, k), 64'(u_if.out_valid), 64'd1);
                check($sformatf("%s.idx[%0d]", name, k), 64'(u_if.out_idx), 64'(exp_q[k].idx));
                check($sformatf("%s.data[%0d]", name, k), u_if.out_data, exp_q[k].data);
                check($sformatf("%s.last[%0d]", name, k), 64'(u_if.out_last), 64'(k == n - 1));
                case (mode)
                    0: rdy = 1'b1;
                    1: begin rdy = tog; tog = !tog; end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                u_if.out_ready = rdy;
                @(negedge clk);
                if (rdy) k++;
                guard++;
            end
            check({name, ".beats"}, 64'(k), 64'(n));
            u_if.out_ready = 1'b0;
            check({name, ".done_valid"}, 64'(u_if.out_valid), 64'd0);
            check({name, ".done_ready"}, 64'(u_if.in_ready), 64'd1);
        end
        $display("vec %s: sew=%0d vl=%0d signed=%0d mask=%h beats=%0d", name, sew, vl, sgn, mask, n);
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".out_valid"}, 64'(u_if.out_valid), 64'd0);
        check({name, ".out_last"}, 64'(u_if.out_last), 64'd0);
        check({name, ".err"}, 64'(u_if.err), 64'd0);
        check({name, ".out_data"}, u_if.out_data, 64'd0);
        check({name, ".out_idx"}, 64'(u_if.out_idx), 64'd0);
        check({name, ".in_ready"}, 64'(u_if.in_ready), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        int          sew;
        rst_n          = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.in_sew    = '0;
        u_if.in_vl     = '0;
        u_if.in_signed = 1'b0;
        u_if.in_mask   = '0;
        u_if.out_ready = 1'b0;

        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("post_reset.in_ready_low", 64'(u_if.in_ready), 64'd0);
        @(negedge clk);
        check("post_reset.in_ready_high", 64'(u_if.in_ready), 64'd1);
        $display("reset released");

        run_vec("sew8_signed", 64'h80FF_0201_7F00_10FE, 0, 8, 1'b1, 8'hFF, 0);
        run_vec("sew32_toggle", 64'h8000_0000_0000_0005, 2, 8, 1'b0, 8'hFF, 1);
        run_vec("sew64_vl0", 64'h1234_5678_9ABC_DEF0, 3, 0, 1'b1, 8'hFF, 0);
        run_vec("sew_illegal", 64'h1234_5678_9ABC_DEF0, 5, 4, 1'b0, 8'hFF, 0);
        run_vec("sew16_signed", 64'h8001_7FFF_FFFF_0042, 1, 4, 1'b1, 8'hFF, 0);
        run_vec("sew64_cap", 64'hF000_0000_0000_0001, 3, 8, 1'b1, 8'hFF, 0);
        run_vec("mask_sparse", 64'h8877_6655_4433_2211, 0, 6, 1'b0, 8'b0010_0101, 0);
        run_vec("mask_none", 64'h8877_6655_4433_2211, 0, 6, 1'b1, 8'hC0, 0);

        // Reset in the middle of a stalled stream.
        d = {$urandom, $urandom};
        build_model(d, 1, 4, 1'b1, 8'hFF);
        wait_ready("mid_reset");
        offer(d, 1, 4, 1'b1, 8'hFF);
        check("mid_reset.first_valid", 64'(u_if.out_valid), 64'd1);
        check("mid_reset.first_data", u_if.out_data, exp_q[0].data);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_reset.rel_ready_low", 64'(u_if.in_ready), 64'd0);
        @(negedge clk);
        check("mid_reset.rel_ready_high", 64'(u_if.in_ready), 64'd1);
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid_reset.no_beat[%0d]", i), 64'(u_if.out_valid), 64'd0);
            @(negedge clk);
        end
        u_if.out_ready = 1'b0;
        $display("vec mid_reset: stream discarded");

        for (int t = 0; t < 25; t++) begin
            sew = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            run_vec($sformatf("rand%0d", t), {$urandom, $urandom}, sew, int'($urandom_range(0, 8)),
                    1'($urandom_range(0, 1)), 8'($urandom), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vunpack.md
VUNPACK -- requirements
Module: vunpack

Interface
REQ-001 Parameter VLEN, default 64: packed vector register width in bits; only 64 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  a packed vector is offered.
REQ-005 in_ready  output  1  block can accept a packed vector.
REQ-006 in_data  input  64  packed vector, with element i at bits [SEWbits*i +: SEWbits].
REQ-007 in_sew  input  3  element width: 0=8b, 1=16b, 2=32b, 3=64b, 4..7 illegal.
REQ-008 in_vl  input  4  requested element count, 0..8.
REQ-009 in_signed  input  1  1 = sign-extend elements, 0 = zero-extend.
REQ-010 in_mask  input  8  element enable bits; used only when VUNPACK_MASK_EN is defined.
REQ-011 out_valid  output  1  an element is presented.
REQ-012 out_ready  input  1  consumer accepts the element.
REQ-013 out_data  output  64  current element, extended to 64 bits.
REQ-014 out_idx  output  3  element index i of out_data.
REQ-015 out_last  output  1  out_data is the final element of the vector.
REQ-016 err  output  1  one-cycle pulse when an illegal SEW is accepted.

Function
REQ-017 The block SHALL have two states: IDLE and STREAM.
REQ-018 in_ready SHALL be 1 exactly when state=IDLE.
REQ-019 Accept: in_valid&in_ready SHALL capture in_data, in_sew, in_signed, in_mask and effective vl.
REQ-020 Effective vl SHALL be min(in_vl, VLEN>>(3+in_sew)).
- SEW=0 caps at 8, SEW=1 at 4, SEW=2 at 2, SEW=3 at 1.
REQ-021 Accept with effective vl>0 and a legal SEW SHALL move the block to STREAM.
- out_valid rises the next cycle, presenting the first active element.
REQ-022 out_data SHALL be the element extended to 64 bits according to the captured signed flag.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-024 Each out_valid&out_ready SHALL advance to the next active element in the following cycle with no bubble, giving one element per cycle under continuous out_ready.
REQ-025 out_last SHALL be 1 only on the highest-index active element.
REQ-026 The handshake on the out_last element SHALL return the block to IDLE.
- out_valid=0 and in_ready=1 in the next cycle.
- A new vector cannot be accepted in that same cycle.
REQ-027 Accept with effective vl=0 SHALL emit no element and stay in IDLE.
REQ-028 Accept with in_sew>3 SHALL emit no element, stay in IDLE and pulse err=1 for the next cycle only.
REQ-029 The captured in_data SHALL be unaffected by input changes after acceptance.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE and set the outputs to:
- out_valid=0, out_last=0, err=0, out_data=0, out_idx=0, in_ready=0.
REQ-031 in_ready SHALL rise in the first clock after rst_n deasserts.
REQ-032 Reset asserted mid-STREAM SHALL discard the in-flight vector; no further elements are emitted.

Configuration
REQ-033 With VUNPACK_MASK_EN defined:
- Elements i with captured in_mask[i]=0 SHALL be skipped in zero cycles.
- out_idx SHALL report the true element index.
- A vector with no active elements within vl SHALL behave as vl=0.
REQ-034 With VUNPACK_MASK_EN undefined:
- in_mask SHALL be ignored, and all elements 0..vl-1 are active.
- No mask storage SHALL be synthesised.

Verification
REQ-035 SEW=0, vl=8, data=64'h80FF_0201_7F00_10FE, signed=1, out_ready=1 -> 8 beats on consecutive cycles: idx0=FFFF_FFFF_FFFF_FFFE, idx1=0000_0000_0000_0010, ..., idx7=FFFF_FFFF_FFFF_FF80; out_last only on idx7; in_ready=1 the cycle after.
REQ-036 SEW=2, vl=8, data=64'h8000_0000_0000_0005, signed=0, out_ready toggling 1/0 -> 2 beats: 0x5 then 0x8000_0000; each beat held stable while out_ready=0.
REQ-037 SEW=3, vl=0 -> no out_valid, block stays IDLE; then SEW=5, vl=4 -> err=1 for exactly one cycle, no out_valid.
REQ-038 SEW=1, vl=4, out_ready=0, reset asserted after the first beat appears -> all outputs 0 immediately; in_ready=1 one cycle after release; no further beats.
REQ-039 With VUNPACK_MASK_EN defined, SEW=0, vl=6, mask=8'b0010_0101 -> beats idx 0, 2, 5 on consecutive cycles, out_last on idx5; mask=8'hC0 with vl=6 -> no beats.
